// File: rtl/instr_queue_fifo_pkg.sv
// Shared constants and entry-field helpers for the instruction queue FIFO.
// An entry is {next_pc, instr}: the upper half holds the PC, the lower half holds the instruction.
package instr_queue_fifo_pkg;

    localparam int IQ_DATA_WIDTH = 64;
    localparam int IQ_ADDR_WIDTH = 5;
    localparam int IQ_PORTS      = 4;
    localparam int IQ_DEPTH      = 2 ** IQ_ADDR_WIDTH;
    localparam int IQ_HALF_WIDTH = IQ_DATA_WIDTH / 2;

    function automatic logic [IQ_HALF_WIDTH-1:0] entry_pc(input logic [IQ_DATA_WIDTH-1:0] e);
        return e[IQ_DATA_WIDTH-1:IQ_HALF_WIDTH];
    endfunction

    function automatic logic [IQ_HALF_WIDTH-1:0] entry_instr(input logic [IQ_DATA_WIDTH-1:0] e);
        return e[IQ_HALF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/instr_queue_fifo_if.sv
// Fetch/decode-side bundle of the instruction queue: push/pop strobes, write data,
// head window outputs and occupancy flags.
interface instr_queue_fifo_if;
    import instr_queue_fifo_pkg::*;

    logic                         flush;
    logic                         push;
    logic [1:0]                   we;
    logic                         pop;
    logic [1:0]                   re;
    logic [IQ_DATA_WIDTH-1:0]     buf_in0, buf_in1, buf_in2, buf_in3;
    logic [IQ_DATA_WIDTH-1:0]     buf_out0, buf_out1, buf_out2, buf_out3;
    logic [IQ_HALF_WIDTH-1:0]     head_element_data0, head_element_data1;
    logic [IQ_HALF_WIDTH-1:0]     head_element_data2, head_element_data3;
    logic [IQ_HALF_WIDTH-1:0]     head_element_pc;
    logic                         buf_empty0, buf_empty1, buf_empty2, buf_empty3;
    logic                         buf_full;
    logic [IQ_ADDR_WIDTH:0]       fifo_counter;

    modport master (
        output flush, push, we, pop, re, buf_in0, buf_in1, buf_in2, buf_in3,
        input  buf_out0, buf_out1, buf_out2, buf_out3,
               head_element_data0, head_element_data1, head_element_data2, head_element_data3,
               head_element_pc, buf_empty0, buf_empty1, buf_empty2, buf_empty3,
               buf_full, fifo_counter
    );

    modport slave (
        input  flush, push, we, pop, re, buf_in0, buf_in1, buf_in2, buf_in3,
        output buf_out0, buf_out1, buf_out2, buf_out3,
               head_element_data0, head_element_data1, head_element_data2, head_element_data3,
               head_element_pc, buf_empty0, buf_empty1, buf_empty2, buf_empty3,
               buf_full, fifo_counter
    );

endinterface

// File: rtl/instr_queue_fifo_regfile.sv
// Storage array for the instruction queue: 4 write ports, 4 combinational read ports.
// Contents are not reset; validity is tracked by the pointer/count logic in the top.
module iq_regfile_4w4r
    import instr_queue_fifo_pkg::*;
(
    input  logic                                       clk,
    input  logic [IQ_PORTS-1:0]                        i_wen,
    input  logic [IQ_PORTS-1:0][IQ_ADDR_WIDTH-1:0]     i_waddr,
    input  logic [IQ_PORTS-1:0][IQ_DATA_WIDTH-1:0]     i_wdata,
    input  logic [IQ_PORTS-1:0][IQ_ADDR_WIDTH-1:0]     i_raddr,
    output logic [IQ_PORTS-1:0][IQ_DATA_WIDTH-1:0]     o_rdata
);

    logic [IQ_DATA_WIDTH-1:0] r_mem [IQ_DEPTH];

    // Write ports target distinct consecutive slots, so their order in the loop never matters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IQ_PORTS; i++) begin
            if (i_wen[i]) begin
                r_mem[i_waddr[i]] <= i_wdata[i];
            end
        end
    end

    // Combinational read of the head window.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < IQ_PORTS; i++) begin
            o_rdata[i] = r_mem[i_raddr[i]];
        end
    end

endmodule

// File: rtl/instr_queue_fifo.sv
// Instruction queue between fetch and decode: multi-entry push/pop circular FIFO
// with a combinational 4-entry head window and flush on redirect.
module instr_queue_fifo
    import instr_queue_fifo_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    instr_queue_fifo_if.slave  bus
);

    localparam int CW = IQ_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    logic [IQ_ADDR_WIDTH-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_nx, w_wr_ptr_nx;
    logic [CW-1:0]            r_count, w_count_nx;
    logic [CW-1:0]            w_n_w, w_n_r, w_popped, w_pushed, w_free;
    logic                     w_push_ok;

    logic [IQ_PORTS-1:0]                     w_wen;
    logic [IQ_PORTS-1:0][IQ_ADDR_WIDTH-1:0]  w_waddr, w_raddr;
    logic [IQ_PORTS-1:0][IQ_DATA_WIDTH-1:0]  w_wdata, w_rdata, w_out;

    // Next-state: pop uses the pre-push count; push is all-or-nothing against post-pop space.
    always_comb begin
        w_n_w = CW'(bus.we) + CW'(1);
        w_n_r = CW'(bus.re) + CW'(1);
        if (bus.pop) begin
            if (w_n_r < r_count) begin
                w_popped = w_n_r;
            end else begin
                w_popped = r_count;
            end
        end else begin
            w_popped = {CW{1'b0}};
        end
        w_free    = DEPTH_C - r_count + w_popped;
        w_push_ok = bus.push && !bus.flush && (w_n_w <= w_free);
        if (w_push_ok) begin
            w_pushed = w_n_w;
        end else begin
            w_pushed = {CW{1'b0}};
        end
        if (bus.flush) begin
            w_rd_ptr_nx = {IQ_ADDR_WIDTH{1'b0}};
            w_wr_ptr_nx = {IQ_ADDR_WIDTH{1'b0}};
            w_count_nx  = {CW{1'b0}};
        end else begin
            w_rd_ptr_nx = r_rd_ptr + w_popped[IQ_ADDR_WIDTH-1:0];
            w_wr_ptr_nx = r_wr_ptr + w_pushed[IQ_ADDR_WIDTH-1:0];
            w_count_nx  = r_count - w_popped + w_pushed;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {IQ_ADDR_WIDTH{1'b0}};
            r_wr_ptr <= {IQ_ADDR_WIDTH{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            r_rd_ptr <= w_rd_ptr_nx;
            r_wr_ptr <= w_wr_ptr_nx;
            r_count  <= w_count_nx;
        end
    end

    // Write/read port addressing and head-window masking of slots beyond the occupancy.
    always_comb begin
        w_wdata = {bus.buf_in3, bus.buf_in2, bus.buf_in1, bus.buf_in0};
        w_wen   = {IQ_PORTS{1'b0}};
        w_waddr = '0;
        w_raddr = '0;
        w_out   = '0;
        for (int i = 0; i < IQ_PORTS; i++) begin
            w_wen[i]   = w_push_ok && (2'(i) <= bus.we);
            w_waddr[i] = r_wr_ptr + IQ_ADDR_WIDTH'(i);
            w_raddr[i] = r_rd_ptr + IQ_ADDR_WIDTH'(i);
            if (r_count > CW'(i)) begin
                w_out[i] = w_rdata[i];
            end else begin
                w_out[i] = {IQ_DATA_WIDTH{1'b0}};
            end
        end
    end

    iq_regfile_4w4r u_regfile (
        .clk     (clk),
        .i_wen   (w_wen),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.buf_out0           = w_out[0];
    assign bus.buf_out1           = w_out[1];
    assign bus.buf_out2           = w_out[2];
    assign bus.buf_out3           = w_out[3];
    assign bus.head_element_data0 = entry_instr(w_out[0]);
    assign bus.head_element_data1 = entry_instr(w_out[1]);
    assign bus.head_element_data2 = entry_instr(w_out[2]);
    assign bus.head_element_data3 = entry_instr(w_out[3]);
    assign bus.head_element_pc    = entry_pc(w_out[0]);
    // Full is conservative: asserted whenever a 4-entry push might not fit.
    assign bus.buf_empty0         = (r_count < CW'(1));
    assign bus.buf_empty1         = (r_count < CW'(2));
    assign bus.buf_empty2         = (r_count < CW'(3));
    assign bus.buf_empty3         = (r_count < CW'(4));
    assign bus.buf_full           = (r_count > (DEPTH_C - CW'(4)));
    assign bus.fifo_counter       = r_count;

endmodule

// File: tb/tb_instr_queue_fifo.sv
// Scoreboard bench for instr_queue_fifo: a queue model tracks expected contents,
// popped entries are checked against the head window and the state is checked each cycle.
module tb_instr_queue_fifo;

    logic clk;
    logic rst_n;
    instr_queue_fifo_if bus();

    instr_queue_fifo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] sb_q[$];
    int total = 0;
    int bad   = 0;
    int seq   = 1;
    int s0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int s);
        logic [31:0] pc;
        logic [31:0] ins;
        pc  = 32'(s * 4);
        ins = 32'hC0DE_0000 | 32'(s);
        return {pc, ins};
    endfunction

    function automatic logic [63:0] out_at(input int i);
        case (i)
            0:       return bus.buf_out0;
            1:       return bus.buf_out1;
            2:       return bus.buf_out2;
            default: return bus.buf_out3;
        endcase
    endfunction

    function automatic logic [31:0] data_at(input int i);
        case (i)
            0:       return bus.head_element_data0;
            1:       return bus.head_element_data1;
            2:       return bus.head_element_data2;
            default: return bus.head_element_data3;
        endcase
    endfunction

    function automatic logic empty_at(input int i);
        case (i)
            0:       return bus.buf_empty0;
            1:       return bus.buf_empty1;
            2:       return bus.buf_empty2;
            default: return bus.buf_empty3;
        endcase
    endfunction

    task automatic check_state();
        logic [63:0] e;
        check_val("count", 64'(bus.fifo_counter), 64'(sb_q.size()));
        check_val("full", 64'(bus.buf_full), 64'(sb_q.size() > 28));
        for (int i = 0; i < 4; i++) begin
            e = (i < sb_q.size()) ? sb_q[i] : 64'h0;
            check_val($sformatf("buf_out%0d", i), out_at(i), e);
            check_val($sformatf("data%0d", i), 64'(data_at(i)), 64'(e[31:0]));
            check_val($sformatf("empty%0d", i), 64'(empty_at(i)), 64'(i >= sb_q.size()));
        end
        e = (sb_q.size() > 0) ? sb_q[0] : 64'h0;
        check_val("head_pc", 64'(bus.head_element_pc), 64'(e[63:32]));
    endtask

    task automatic step(input logic f, input logic p, input logic [1:0] w,
                        input logic pp, input logic [1:0] r);
        logic [63:0] ins[4];
        logic [63:0] exp;
        int np;
        int nw;
        for (int k = 0; k < 4; k++) ins[k] = mk(seq + k);
        bus.flush = f; bus.push = p; bus.we = w; bus.pop = pp; bus.re = r;
        bus.buf_in0 = ins[0]; bus.buf_in1 = ins[1]; bus.buf_in2 = ins[2]; bus.buf_in3 = ins[3];
        if (f) begin
            sb_q.delete();
        end else begin
            if (pp) begin
                np = int'(r) + 1;
                if (np > sb_q.size()) np = sb_q.size();
                for (int k = 0; k < np; k++) begin
                    exp = sb_q.pop_front();
                    check_val("pop_data", out_at(k), exp);
                end
            end
            if (p) begin
                nw = int'(w) + 1;
                if (nw <= 32 - sb_q.size()) begin
                    for (int k = 0; k < nw; k++) sb_q.push_back(ins[k]);
                    seq += nw;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        check_state();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        bus.we = 2'd0; bus.re = 2'd0;
        bus.buf_in0 = 64'h0; bus.buf_in1 = 64'h0; bus.buf_in2 = 64'h0; bus.buf_in3 = 64'h0;
        #12;
        check_state();
        rst_n = 1'b1;

        // four entries in one cycle
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        check_val("t1_cnt", 64'(bus.fifo_counter), 64'd4);
        check_val("t1_pc", 64'(bus.head_element_pc), 64'd4);
        check_val("t1_d0", 64'(bus.head_element_data0), 64'h0000_0000_C0DE_0001);
        check_val("t1_d3", 64'(bus.head_element_data3), 64'h0000_0000_C0DE_0004);
        check_val("t1_e3", 64'(bus.buf_empty3), 64'd0);

        // pop two
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd1);
        check_val("t2_cnt", 64'(bus.fifo_counter), 64'd2);
        check_val("t2_d0", 64'(bus.head_element_data0), 64'h0000_0000_C0DE_0003);
        check_val("t2_d1", 64'(bus.head_element_data1), 64'h0000_0000_C0DE_0004);
        check_val("t2_e2", 64'(bus.buf_empty2), 64'd1);
        check_val("t2_out2", bus.buf_out2, 64'h0);

        // drain with an over-sized pop, then pop empty
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        check_val("empty_pop_cnt", 64'(bus.fifo_counter), 64'd0);

        // fill to 28, 29, then a dropped 4-push
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        check_val("full28", 64'(bus.buf_full), 64'd0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        check_val("full29", 64'(bus.buf_full), 64'd1);
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        check_val("drop_cnt", 64'(bus.fifo_counter), 64'd29);

        // wrap: 30 entries, pop 4 x7, push 4 x3
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        check_val("wrap_cnt", 64'(bus.fifo_counter), 64'd14);

        // flush beats simultaneous push and pop on 10 entries
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
        check_val("pre_flush", 64'(bus.fifo_counter), 64'd10);
        step(1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
        check_val("flush_cnt", 64'(bus.fifo_counter), 64'd0);
        check_val("flush_e0", 64'(bus.buf_empty0), 64'd1);
        s0 = seq;
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        check_val("post_flush", bus.buf_out0, mk(s0));

        // same-cycle pop 2 / push 3 on 5 entries
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        step(1'b0, 1'b1, 2'd2, 1'b1, 2'd1);
        check_val("pp_cnt", 64'(bus.fifo_counter), 64'd6);
        check_val("pp_head", bus.buf_out0, mk(s0 + 2));

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // async reset mid-cycle
        step(1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_state();
        check_val("rst_cnt", 64'(bus.fifo_counter), 64'd0);
        #2;
        rst_n = 1'b1;
        s0 = seq;
        step(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
        check_val("post_rst", bus.buf_out0, mk(s0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
